// File: rtl/avst_pkt_gen.sv
// Avalon-ST burst packet source: start_i launches pkt_count packets of len beats with an IPG.
// Optional AVST_PKT_GEN_LFSR_EN selects a 32-bit Galois LFSR payload instead of a counter.
module avst_pkt_gen #(
  parameter int unsigned channel_width = 4,
  parameter int unsigned data_width    = 32,
  parameter int unsigned empty_width   = 2,
  parameter int unsigned len_width     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [len_width-1:0]     pkt_count_i,
  input  logic [len_width-1:0]     len_i,
  input  logic [len_width-1:0]     ipg_i,
  input  logic [channel_width-1:0] channel_i,
  input  logic [empty_width-1:0]   empty_last_i,
  input  logic [data_width-1:0]    seed_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [len_width-1:0]     pkts_sent_o,
  output logic [channel_width-1:0] avst_channel_o,
  output logic                     avst_sop_o,
  output logic                     avst_eop_o,
  output logic [empty_width-1:0]   avst_empty_o,
  output logic [data_width-1:0]    avst_data_o,
  output logic                     avst_valid_o,
  input  logic                     avst_ready_i
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                   state_q, state_d;
  logic [len_width-1:0]     cnt_q, cnt_d, len_q, len_d, ipg_q, ipg_d;
  logic [len_width-1:0]     beat_q, beat_d, gap_q, gap_d, pkts_q, pkts_d;
  logic [len_width-1:0]     beat_nxt, pkts_nxt;
  logic [empty_width-1:0]   elast_q, elast_d, empty_q, empty_d;
  logic [channel_width-1:0] chan_q, chan_d;
  logic [data_width-1:0]    data_q, data_d;
  logic                     valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic                     busy_q, done_q, done_d;

`ifdef AVST_PKT_GEN_LFSR_EN
  // Right-shifting Galois form of x^32+x^22+x^2+x^1+1
  function automatic logic [data_width-1:0] step_data(input logic [data_width-1:0] d);
    step_data = d[0] ? ((d >> 1) ^ data_width'(32'h8020_0003)) : (d >> 1);
  endfunction

  function automatic logic [data_width-1:0] seed_init(input logic [data_width-1:0] s);
    seed_init = (s == '0) ? data_width'(1) : s;
  endfunction
`else
  function automatic logic [data_width-1:0] step_data(input logic [data_width-1:0] d);
    step_data = d + data_width'(1);
  endfunction

  function automatic logic [data_width-1:0] seed_init(input logic [data_width-1:0] s);
    seed_init = s;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ipg_d    = ipg_q;
    elast_d  = elast_q;
    chan_d   = chan_q;
    beat_d   = beat_q;
    gap_d    = gap_q;
    pkts_d   = pkts_q;
    data_d   = data_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    empty_d  = empty_q;
    done_d   = 1'b0;
    beat_nxt = beat_q + len_width'(1);
    pkts_nxt = pkts_q + len_width'(1);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          pkts_d = '0;
          if (pkt_count_i != '0 && len_i != '0) begin
            state_d = SEND;
            cnt_d   = pkt_count_i;
            len_d   = len_i;
            ipg_d   = ipg_i;
            elast_d = empty_last_i;
            chan_d  = channel_i;
            data_d  = seed_init(seed_i);
            beat_d  = '0;
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = (len_i == len_width'(1));
            empty_d = eop_d ? empty_last_i : '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (valid_q && avst_ready_i) begin
          data_d = step_data(data_q);
          if (eop_q) begin
            pkts_d = pkts_nxt;
            if (pkts_nxt == cnt_q) begin
              state_d = IDLE;
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
              empty_d = '0;
              done_d  = 1'b1;
            end else if (ipg_q == '0) begin
              beat_d  = '0;
              sop_d   = 1'b1;
              eop_d   = (len_q == len_width'(1));
              empty_d = eop_d ? elast_q : '0;
            end else begin
              state_d = GAP;
              gap_d   = '0;
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
              empty_d = '0;
            end
          end else begin
            beat_d  = beat_nxt;
            sop_d   = 1'b0;
            eop_d   = (beat_nxt == len_q - len_width'(1));
            empty_d = eop_d ? elast_q : '0;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + len_width'(1);
        // gap_q counts idle cycles already shown; the last one re-arms the next sop
        if (gap_q == ipg_q - len_width'(1)) begin
          state_d = SEND;
          beat_d  = '0;
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = (len_q == len_width'(1));
          empty_d = eop_d ? elast_q : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      len_q   <= '0;
      ipg_q   <= '0;
      elast_q <= '0;
      chan_q  <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      pkts_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ipg_q   <= ipg_d;
      elast_q <= elast_d;
      chan_q  <= chan_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      pkts_q  <= pkts_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      empty_q <= empty_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pkts_sent_o    = pkts_q;
  assign avst_channel_o = chan_q;
  assign avst_sop_o     = sop_q;
  assign avst_eop_o     = eop_q;
  assign avst_empty_o   = empty_q;
  assign avst_data_o    = data_q;
  assign avst_valid_o   = valid_q;

endmodule
